// File: rtl/udp_packet_builder.sv
// rtl/udp_packet_builder.sv - UDP header + payload byte-stream builder.
// Define UDP_TX_CHECKSUM_EN to send a computed header checksum instead of 0x0000.
module udp_packet_builder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] src_port_in,
    input  logic [15:0] dst_port_in,
    input  logic [15:0] payload_len_in,
    input  logic [7:0]  payload_data_in,
    input  logic        payload_valid_in,
    output logic        payload_ready_out,
    output logic [7:0]  data_out,
    output logic        data_valid_out,
    input  logic        data_ready_in,
    output logic        last_out,
    output logic        busy,
    output logic        len_error,
    output logic [15:0] pkt_count_out
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_LATCH   = 2'd1;
    localparam logic [1:0]  S_HEADER  = 2'd2;
    localparam logic [1:0]  S_PAYLOAD = 2'd3;

    // Largest payload whose udp_len (payload + 8) still fits in 16 bits.
    localparam logic [15:0] MAX_PAYLOAD = 16'd65527;

    logic [1:0]  state_q,   state_d;
    logic [15:0] src_q,     src_d;
    logic [15:0] dst_q,     dst_d;
    logic [15:0] plen_q,    plen_d;
    logic [15:0] udp_len_q, udp_len_d;
    logic [15:0] remain_q,  remain_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic        len_err_q, len_err_d;

    logic [15:0] udp_len_calc;
    logic [15:0] csum_w;
    logic [7:0]  hdr_byte;
    logic        hdr_active;
    logic        pay_active;
    logic        xfer;

    assign udp_len_calc = plen_q + 16'd8;

`ifdef UDP_TX_CHECKSUM_EN
    logic [15:0] csum_q;
    logic [15:0] csum_calc;
    logic [17:0] sum_raw;
    logic [16:0] sum_fold1;
    logic [15:0] sum_fold2;

    // Ones-complement sum with end-around carry; two folds suffice for three terms.
    always_comb begin
        sum_raw   = {2'b00, src_q} + {2'b00, dst_q} + {2'b00, udp_len_calc};
        sum_fold1 = {1'b0, sum_raw[15:0]} + {15'd0, sum_raw[17:16]};
        sum_fold2 = sum_fold1[15:0] + {15'd0, sum_fold1[16]};
        csum_calc = ~sum_fold2;
        if (csum_calc == 16'h0000) begin
            csum_calc = 16'hFFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= 16'h0000;
        end else if (state_q == S_LATCH) begin
            csum_q <= csum_calc;
        end
    end

    assign csum_w = csum_q;
`else
    assign csum_w = 16'h0000;
`endif

    always_comb begin
        case (hdr_idx_q)
            3'd0:    hdr_byte = src_q[15:8];
            3'd1:    hdr_byte = src_q[7:0];
            3'd2:    hdr_byte = dst_q[15:8];
            3'd3:    hdr_byte = dst_q[7:0];
            3'd4:    hdr_byte = udp_len_q[15:8];
            3'd5:    hdr_byte = udp_len_q[7:0];
            3'd6:    hdr_byte = csum_w[15:8];
            default: hdr_byte = csum_w[7:0];
        endcase
    end

    assign hdr_active = (state_q == S_HEADER);
    assign pay_active = (state_q == S_PAYLOAD);

    // Outputs are gated by rst so nothing leaks while reset is held mid-packet.
    assign data_valid_out    = !rst && (hdr_active || (pay_active && payload_valid_in));
    assign data_out          = pay_active ? payload_data_in : hdr_byte;
    assign payload_ready_out = !rst && pay_active && data_ready_in;
    assign last_out          = data_valid_out &&
                               ((hdr_active && (hdr_idx_q == 3'd7) && (plen_q == 16'd0)) ||
                                (pay_active && (remain_q == 16'd1)));
    assign xfer              = data_valid_out && data_ready_in;
    assign busy              = !rst && (state_q != S_IDLE);
    assign len_error         = !rst && len_err_q;
    assign pkt_count_out     = rst ? 16'h0000 : pkt_cnt_q;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        plen_d    = plen_q;
        udp_len_d = udp_len_q;
        remain_d  = remain_q;
        hdr_idx_d = hdr_idx_q;
        pkt_cnt_d = pkt_cnt_q;
        len_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (payload_len_in <= MAX_PAYLOAD) begin
                        src_d     = src_port_in;
                        dst_d     = dst_port_in;
                        plen_d    = payload_len_in;
                        remain_d  = payload_len_in;
                        hdr_idx_d = 3'd0;
                        state_d   = S_LATCH;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            S_LATCH: begin
                udp_len_d = udp_len_calc;
                state_d   = S_HEADER;
            end
            S_HEADER: begin
                if (xfer) begin
                    if (hdr_idx_q == 3'd7) begin
                        if (plen_q == 16'd0) begin
                            pkt_cnt_d = pkt_cnt_q + 16'd1;
                            state_d   = S_IDLE;
                        end else begin
                            state_d   = S_PAYLOAD;
                        end
                    end else begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            src_q     <= 16'h0000;
            dst_q     <= 16'h0000;
            plen_q    <= 16'h0000;
            udp_len_q <= 16'h0000;
            remain_q  <= 16'h0000;
            hdr_idx_q <= 3'd0;
            pkt_cnt_q <= 16'h0000;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            plen_q    <= plen_d;
            udp_len_q <= udp_len_d;
            remain_q  <= remain_d;
            hdr_idx_q <= hdr_idx_d;
            pkt_cnt_q <= pkt_cnt_d;
            len_err_q <= len_err_d;
        end
    end

endmodule

// File: tb/tb_udp_packet_builder.sv
// tb/tb_udp_packet_builder.sv - scoreboard bench for udp_packet_builder.
module tb_udp_packet_builder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_port_in;
    logic [15:0] dst_port_in;
    logic [15:0] payload_len_in;
    logic [7:0]  payload_data_in;
    logic        payload_valid_in;
    logic        payload_ready_out;
    logic [7:0]  data_out;
    logic        data_valid_out;
    logic        data_ready_in;
    logic        last_out;
    logic        busy;
    logic        len_error;
    logic [15:0] pkt_count_out;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    logic [7:0] pay_q[$];

`ifdef UDP_TX_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    udp_packet_builder dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .src_port_in       (src_port_in),
        .dst_port_in       (dst_port_in),
        .payload_len_in    (payload_len_in),
        .payload_data_in   (payload_data_in),
        .payload_valid_in  (payload_valid_in),
        .payload_ready_out (payload_ready_out),
        .data_out          (data_out),
        .data_valid_out    (data_valid_out),
        .data_ready_in     (data_ready_in),
        .last_out          (last_out),
        .busy              (busy),
        .len_error         (len_error),
        .pkt_count_out     (pkt_count_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_byte(input logic [7:0] b, input logic last);
        exp_q.push_back({last, b});
    endtask

    task automatic exp_hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] ulen,
                           input logic [15:0] csum, input logic last7);
        logic [15:0] c;
        c = CSUM_EN ? csum : 16'h0000;
        exp_byte(src[15:8], 1'b0);
        exp_byte(src[7:0], 1'b0);
        exp_byte(dst[15:8], 1'b0);
        exp_byte(dst[7:0], 1'b0);
        exp_byte(ulen[15:8], 1'b0);
        exp_byte(ulen[7:0], 1'b0);
        exp_byte(c[15:8], 1'b0);
        exp_byte(c[7:0], last7);
    endtask

    // Monitor: pops the scoreboard on every transfer, and checks stall stability.
    logic       stalled = 1'b0;
    logic [7:0] stall_data;
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (stalled) begin
                    check("hold_valid", data_valid_out, 1);
                    check("hold_data", data_out, stall_data);
                end
                if (last_out && !data_valid_out) begin
                    check("last_without_valid", last_out, 0);
                end
                if (data_valid_out && data_ready_in) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte: got %0h expected no byte", data_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", data_out, e[7:0]);
                        check("last", last_out, e[8]);
                    end
                end
                stalled    = data_valid_out && !data_ready_in;
                stall_data = data_out;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic run_pkt(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                           input int npkts, input bit stall, input bit gap, input int stop_after,
                           output int idle_cnt);
        int lasts = 0;
        int xfers = 0;
        int iter  = 0;
        bit offering = 1'b0;
        bit done = 1'b0;
        idle_cnt = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            src_port_in    = src;
            dst_port_in    = dst;
            payload_len_in = len;
            start          = (npkts > 1) ? 1'b1 : (iter == 0);
            data_ready_in  = stall ? ((iter % 4 == 0) || (iter % 4 == 3)) : 1'b1;
            if (!offering) offering = gap ? (iter % 3 != 1) : 1'b1;
            payload_valid_in = offering && (pay_q.size() > 0);
            payload_data_in  = (pay_q.size() > 0) ? pay_q[0] : 8'h00;
            @(negedge clk);
            if (!busy) idle_cnt++;
            if (payload_ready_out && payload_valid_in) begin
                void'(pay_q.pop_front());
                offering = 1'b0;
            end
            if (data_valid_out && data_ready_in) begin
                xfers++;
                if (last_out) lasts++;
            end
            iter++;
            if (lasts == npkts || (stop_after > 0 && xfers == stop_after)) begin
                done = 1'b1;
            end else if (iter > 400) begin
                total++;
                bad++;
                $display("FAIL timeout: got %0d last transfers expected %0d", lasts, npkts);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        start            = 1'b0;
        payload_valid_in = 1'b0;
        data_ready_in    = 1'b1;
    endtask

    initial begin
        int idle;
        rst = 1'b1;
        start = 1'b0;
        src_port_in = '0;
        dst_port_in = '0;
        payload_len_in = '0;
        payload_data_in = '0;
        payload_valid_in = 1'b0;
        data_ready_in = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", data_valid_out, 0);
        check("rst_pready", payload_ready_out, 0);
        check("rst_last", last_out, 0);
        check("rst_busy", busy, 0);
        check("rst_len_error", len_error, 0);
        check("rst_pkt_count", pkt_count_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_valid", data_valid_out, 0);
        check("idle_pkt_count", pkt_count_out, 0);

        // Reference packet with 4-byte payload.
        exp_hdr(16'h1234, 16'h0050, 16'h000C, 16'hED6F, 1'b0);
        exp_byte(8'hDE, 1'b0); exp_byte(8'hAD, 1'b0); exp_byte(8'hBE, 1'b0); exp_byte(8'hEF, 1'b1);
        pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_pkt(16'h1234, 16'h0050, 16'd4, 1, 1'b0, 1'b0, 0, idle);
        @(negedge clk);
        check("a_busy", busy, 0);
        check("a_pkt_count", pkt_count_out, 1);

        // Empty payload: last on header byte 7.
        exp_hdr(16'h0001, 16'h0002, 16'h0008, 16'hFFF4, 1'b1);
        run_pkt(16'h0001, 16'h0002, 16'd0, 1, 1'b0, 1'b0, 0, idle);
        @(negedge clk);
        check("b_busy", busy, 0);
        check("b_pkt_count", pkt_count_out, 2);

        // Stalled header and gapped payload; checksum needs end-around carry.
        exp_hdr(16'h8000, 16'h8001, 16'h000B, 16'hFFF2, 1'b0);
        exp_byte(8'h11, 1'b0); exp_byte(8'h22, 1'b0); exp_byte(8'h33, 1'b1);
        pay_q = '{8'h11, 8'h22, 8'h33};
        run_pkt(16'h8000, 16'h8001, 16'd3, 1, 1'b1, 1'b1, 0, idle);
        @(negedge clk);
        check("c_pkt_count", pkt_count_out, 3);

        // Checksum that computes to zero is sent as FFFF.
        exp_hdr(16'hFFF7, 16'h0000, 16'h0008, 16'hFFFF, 1'b1);
        run_pkt(16'hFFF7, 16'h0000, 16'd0, 1, 1'b0, 1'b0, 0, idle);
        @(negedge clk);
        check("d_pkt_count", pkt_count_out, 4);

        // Oversize length rejected.
        @(posedge clk);
        #1 start = 1'b1; payload_len_in = 16'd65528;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("lenerr_pulse", len_error, 1);
        check("lenerr_busy", busy, 0);
        @(negedge clk);
        check("lenerr_clear", len_error, 0);
        check("lenerr_busy2", busy, 0);
        check("lenerr_pkt_count", pkt_count_out, 4);

        // Reset after header byte 3 abandons the packet.
        exp_byte(8'h12, 1'b0); exp_byte(8'h34, 1'b0); exp_byte(8'h00, 1'b0); exp_byte(8'h50, 1'b0);
        pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_pkt(16'h1234, 16'h0050, 16'd4, 1, 1'b0, 1'b0, 4, idle);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_valid_in_rst", data_valid_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_valid", data_valid_out, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_pkt_count", pkt_count_out, 0);
        pay_q.delete();

        exp_hdr(16'hABCD, 16'h0007, 16'h0009, 16'h5422, 1'b0);
        exp_byte(8'h5A, 1'b1);
        pay_q = '{8'h5A};
        run_pkt(16'hABCD, 16'h0007, 16'd1, 1, 1'b0, 1'b0, 0, idle);
        @(negedge clk);
        check("e_pkt_count", pkt_count_out, 1);

        // Largest legal length is accepted; abandoned by reset.
        @(posedge clk);
        #1 data_ready_in = 1'b0; start = 1'b1; payload_len_in = 16'd65527;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("maxlen_busy", busy, 1);
        check("maxlen_len_error", len_error, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; data_ready_in = 1'b1;
        @(negedge clk);
        check("maxlen_rst_busy", busy, 0);
        check("maxlen_rst_pkt_count", pkt_count_out, 0);

        // start held high: three back-to-back packets.
        for (int p = 0; p < 3; p++) begin
            exp_hdr(16'h0100, 16'h0200, 16'h000A, 16'hFCF5, 1'b0);
        end
        exp_q.delete();
        for (int p = 0; p < 3; p++) begin
            logic [7:0] b0;
            b0 = 8'(2 * p + 1);
            exp_hdr(16'h0100, 16'h0200, 16'h000A, 16'hFCF5, 1'b0);
            exp_byte(b0, 1'b0);
            exp_byte(b0 + 8'd1, 1'b1);
        end
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_pkt(16'h0100, 16'h0200, 16'd2, 3, 1'b0, 1'b0, 0, idle);
        check("b2b_idle_cycles", idle, 3);
        @(negedge clk);
        check("b2b_pkt_count", pkt_count_out, 3);
        check("b2b_busy", busy, 0);

        repeat (5) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("payload_consumed", pay_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_packet_builder.md
UDP_PACKET_BUILDER -- requirements
Module: udp_packet_builder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: start  in  1  request to build one packet, sampled only in IDLE.
REQ-004 SHALL have: src_port_in  in  16; dst_port_in  in  16; payload_len_in  in  16 (payload bytes), all sampled with an accepted start.
REQ-005 SHALL have: payload_data_in  in  8; payload_valid_in  in  1; payload_ready_out  out  1 (upstream payload stream).
REQ-006 SHALL have: data_out  out  8; data_valid_out  out  1; data_ready_in  in  1; last_out  out  1 (downstream byte stream).
REQ-007 SHALL have: busy  out  1 (state != IDLE); len_error  out  1 (one-cycle pulse); pkt_count_out  out  16 (packets completed).

Function
REQ-008 SHALL implement states IDLE, LATCH, HEADER, PAYLOAD.
REQ-009 A start is accepted in IDLE if payload_len_in <= 65527; the block then latches ports and length and enters LATCH.
REQ-010 start in IDLE with payload_len_in > 65527 SHALL be rejected: state stays IDLE, len_error pulses high the next cycle.
REQ-011 start outside IDLE SHALL be ignored, with no len_error.
REQ-012 LATCH SHALL last exactly one cycle, registering udp_len = payload_len + 8 and the checksum; the next state is HEADER.
REQ-013 The first header byte SHALL be presented with data_valid_out=1 two cycles after the accepting edge.
REQ-014 HEADER SHALL emit 8 bytes in big-endian order: src hi, src lo, dst hi, dst lo, len hi, len lo, csum hi, csum lo.
REQ-015 A byte transfers only when data_valid_out && data_ready_in. data_out and data_valid_out SHALL hold stable while data_ready_in=0.
REQ-016 payload_ready_out SHALL be 0 in IDLE, LATCH and HEADER.
REQ-017 In PAYLOAD: data_out = payload_data_in, data_valid_out = payload_valid_in, payload_ready_out = data_ready_in (combinational pass-through, zero latency).
REQ-018 A remaining-byte counter SHALL decrement on each payload transfer. last_out SHALL be 1 on the final payload byte only.
REQ-019 payload_len=0 SHALL assert last_out on header byte 7, skip PAYLOAD, and return to IDLE.
REQ-020 After the transfer carrying last_out, the state SHALL be IDLE on the next edge, and a new start SHALL be acceptable in that IDLE cycle.
REQ-021 pkt_count_out SHALL increment on each last_out transfer, wrapping 0xFFFF->0x0000.
REQ-022 last_out SHALL be 0 whenever data_valid_out is 0.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, clear the remaining counter, header index and pkt_count_out, and deassert len_error, regardless of current state.
REQ-024 While in reset and on the following IDLE cycle: data_valid_out=0, payload_ready_out=0, last_out=0, busy=0, len_error=0, pkt_count_out=0.
REQ-025 Reset mid-packet SHALL abandon the packet. No further bytes of it SHALL be emitted, and the counter SHALL not increment.

Configuration
REQ-026 Macro UDP_TX_CHECKSUM_EN. When defined, the checksum SHALL be computed from src_port, dst_port and udp_len.
REQ-027 The checksum computation SHALL use a 16-bit ones-complement sum with end-around carry, then bitwise invert.
REQ-028 A computed checksum of 0x0000 SHALL be sent as 0xFFFF.
REQ-029 When UDP_TX_CHECKSUM_EN is undefined, the checksum bytes SHALL be 0x00,0x00 and no checksum logic SHALL be synthesized; all else is unchanged.

Verification
REQ-030 start, src=0x1234, dst=0x0050, len=4, payload DE AD BE EF, ready=1 -> bytes 12 34 00 50 00 0C ED 6F DE AD BE EF. last_out on EF; pkt_count_out 0->1. Checksum bytes are 00 00 without UDP_TX_CHECKSUM_EN.
REQ-031 len=0, src=0x0001, dst=0x0002 -> 8 bytes ending 00 08 FF F4, last_out on byte 7, busy low the next cycle.
REQ-032 data_ready_in toggled 1,0,0,1 during header and payload_valid_in gapped -> each byte is sent exactly once and held stable while stalled.
REQ-033 payload_len_in=65528 with start -> len_error pulse for one cycle; busy stays 0; no output.
REQ-034 rst asserted after header byte 3 -> next cycle data_valid_out=0 and pkt_count_out=0. A following start with len=1 produces a complete 9-byte packet.
REQ-035 start held high continuously for three packets -> back-to-back packets with one IDLE cycle between them; pkt_count_out=3.
